// File: rtl/collision_event_handler.sv
// collision_event_handler: folds per-pixel collision flags into at most one
// event per frame per source. Flags are gathered in sticky latches, frozen
// into a snapshot at startOfFrame, and evaluated on the following cycle.
// Character hits pass through a frame-counted invulnerability window; life
// pickup is edge-detected across frames.
module collision_event_handler #(
  parameter int INVULN_FRAMES = 60
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic bubbleHitChar_1,
  input  logic bubbleHitChar_2,
  input  logic arrow_1_HitBubble,
  input  logic arrow_2_HitBubble,
  input  logic lifeHitChar,
  output logic char1Hit,
  output logic char2Hit,
  output logic arrow1Pop,
  output logic arrow2Pop,
  output logic lifeCollected,
  output logic invuln_1,
  output logic invuln_2
);

  // A zero-frame window still needs a 1-bit counter; it just never leaves 0.
  localparam int CW = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(INVULN_FRAMES);

  // Bit positions in the flag vectors.
  localparam int A1 = 2;
  localparam int A2 = 3;
  localparam int LF = 4;

  logic [4:0] raw;
  logic [4:0] latch_q, latch_d;
  logic [4:0] snap_q, snap_d;
  logic       eval_q;
  logic       prev_life_q, prev_life_d;
  logic [1:0] hit;
  logic [1:0] inv;

  assign raw = {lifeHitChar, arrow_2_HitBubble, arrow_1_HitBubble,
                bubbleHitChar_2, bubbleHitChar_1};

  // Sticky accumulation; a flag on the startOfFrame cycle seeds the new frame.
  always_comb begin
    latch_d     = startOfFrame ? raw : (latch_q | raw);
    snap_d      = startOfFrame ? latch_q : snap_q;
    prev_life_d = eval_q ? snap_q[LF] : prev_life_q;
  end

  // Latches, snapshot, evaluation strobe and previous-life register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      latch_q     <= '0;
      snap_q      <= '0;
      eval_q      <= 1'b0;
      prev_life_q <= 1'b0;
    end else begin
      latch_q     <= latch_d;
      snap_q      <= snap_d;
      eval_q      <= startOfFrame;
      prev_life_q <= prev_life_d;
    end
  end

  // Per-character invulnerability: hits only count while the counter is idle.
  for (genvar n = 0; n < 2; n++) begin : g_char
    logic [CW-1:0] cnt_q, cnt_d;

    assign hit[n] = eval_q & snap_q[n] & (cnt_q == '0);
    assign inv[n] = (cnt_q != '0);

    // Decrement once per evaluation while armed; reload on an accepted hit.
    always_comb begin
      cnt_d = cnt_q;
      if (eval_q) begin
        if (cnt_q != '0)    cnt_d = cnt_q - CW'(1);
        else if (snap_q[n]) cnt_d = RELOAD;
      end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end
  end

  assign char1Hit      = hit[0];
  assign char2Hit      = hit[1];
  assign invuln_1      = inv[0];
  assign invuln_2      = inv[1];
  assign arrow1Pop     = eval_q & snap_q[A1];
  assign arrow2Pop     = eval_q & snap_q[A2];
  assign lifeCollected = eval_q & snap_q[LF] & ~prev_life_q;

endmodule

// File: doc/collision_event_handler.md
Name: collision_event_handler

Overview:
- Receiving end of the per-pixel collision flags from border_crash.
- Raw flags are combinational and pulse once per overlapping pixel, i.e. many cycles per frame. This block gathers them across a frame and turns them into at most one clean event per frame per source.
- Events go to game logic: character damage, arrow retract, bubble split and life pickup.
- Character hits are filtered by a per-character invulnerability window counted in frames. Life pickup is edge-detected across frames.

Parameters:
INVULN_FRAMES, 60, frames a character ignores bubble hits after a reported hit (0 = no invulnerability)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at the start of each frame from the VGA controller
- bubbleHitChar_1  in  1  raw flag: bubble overlaps character 1
- bubbleHitChar_2  in  1  raw flag: bubble overlaps character 2
- arrow_1_HitBubble  in  1  raw flag: arrow 1 overlaps a bubble
- arrow_2_HitBubble  in  1  raw flag: arrow 2 overlaps a bubble
- lifeHitChar  in  1  raw flag: life object overlaps either character
- char1Hit  out  1  one-cycle pulse: character 1 took a hit this frame
- char2Hit  out  1  one-cycle pulse: character 2 took a hit this frame
- arrow1Pop  out  1  one-cycle pulse: arrow 1 hit a bubble last frame
- arrow2Pop  out  1  one-cycle pulse: arrow 2 hit a bubble last frame
- lifeCollected  out  1  one-cycle pulse: new life contact
- invuln_1  out  1  level: character 1 invulnerable
- invuln_2  out  1  level: character 2 invulnerable

Behaviour:
- Reset (resetN low, asynchronous): all sticky latches, frame snapshots, the previous-life register, both invulnerability counters and all outputs go to 0. Reset mid-frame discards every pending collision.
- Sticky latches (one per input):
  - Set on any cycle where the input is 1; hold until startOfFrame.
  - On a startOfFrame cycle, latch_next = current input value, so a flag coinciding with startOfFrame belongs to the new frame.
- Snapshot:
  - On the startOfFrame cycle, the old latch values are copied to snapshot registers.
  - Event evaluation happens the following cycle, so output pulses appear exactly 1 cycle after startOfFrame and last exactly 1 cycle.
  - No output pulse occurs at any other time.
- Arrows: arrowNPop = snapshot of arrow_N_HitBubble. Fires every frame the overlap existed, with no suppression.
- Life:
  - lifeCollected = life snapshot AND NOT prevLife. prevLife updates to the life snapshot at the evaluation cycle.
  - Continuous contact over many frames yields one pulse; contact must be absent for a full frame before a second pulse.
- Characters (independent per N):
  - Counter width is clog2(INVULN_FRAMES+1); the counter saturates at 0 and never wraps.
  - Evaluation cycle, counter == 0 and snapshot bubbleHitChar_N = 1: charNHit pulses and the counter loads INVULN_FRAMES.
  - Evaluation cycle, counter > 0: the counter decrements by 1 and the hit snapshot is ignored (no pulse, no reload).
  - invuln_N = (counter != 0). It therefore goes high in the cycle after the charNHit pulse and stays high for INVULN_FRAMES frames.
  - INVULN_FRAMES = 0: every frame with overlap pulses charNHit and invuln_N stays 0.
- Simultaneous events: all outputs are independent and may pulse in the same cycle. Both characters can be hit in the same frame.
- startOfFrame spacing: back-to-back startOfFrame pulses are legal. Each closes a frame; an empty frame yields no events.

Test Plan:
- Reset: resetN=0 mid-frame with all inputs high, release, then startOfFrame -> all outputs 0 in the evaluation cycle; invuln_1/2=0.
- Arrow aggregation: arrow_1_HitBubble high for 37 scattered cycles in frame k -> exactly one arrow1Pop pulse, 1 cycle after the startOfFrame closing frame k. Nothing the next frame if the input stays low.
- Invulnerability (INVULN_FRAMES=3): bubbleHitChar_1 high in every frame.
  - char1Hit pulses after frames 0 and 4 only.
  - invuln_1 is high across evaluation cycles 1 to 3.
  - char2Hit stays 0.
- Life edge: lifeHitChar high in frames 0 to 5, low in frame 6, high in frame 7 -> lifeCollected pulses after frame 0 and after frame 7 only.
- Boundary flag: bubbleHitChar_2 high only on the startOfFrame cycle that closes frame k -> no char2Hit after frame k; char2Hit pulses after frame k+1.
- Simultaneous: all five inputs high in one frame with counters at 0 -> char1Hit, char2Hit, arrow1Pop, arrow2Pop and lifeCollected pulse together in the same cycle.
